// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the rv32i pipeline.
// Owns the PC, the instruction-memory read handshake and a direct-mapped BTB
// with 2-bit saturating counters. It feeds the IF/ID register and honours
// stall back-pressure and EX redirects.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_in            IF/ID cannot accept the presented instruction
//   redirect/_pc        EX mispredict/jump; fetch restarts at redirect_pc
//   btb_update*         resolved control-flow outcome from EX
//   imem_read/_addr     read request; address held until imem_resp
//   imem_resp/_rdata    read data valid / instruction word
//   pc_reg              PC of the presented instruction
//   instr_mem_rdata     presented instruction (nop when not valid)
//   br_pred_taken/_pc   BTB prediction for the presented instruction
//   fetch_valid         presented instruction is real (low = bubble)
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h6000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        btb_update,
  input  logic [31:0] btb_update_pc,
  input  logic [31:0] btb_update_target,
  input  logic        btb_update_taken,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_reg,
  output logic [31:0] instr_mem_rdata,
  output logic        br_pred_taken,
  output logic [31:0] br_pred_pc,
  output logic        fetch_valid
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] saved_redirect_pc;

  // Hold buffer: word and prediction captured when the response meets a stall.
  logic [31:0] hold_word;
  logic        hold_taken;
  logic [31:0] hold_pred_pc;
  logic [31:0] hold_npc;

  // BTB storage
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  // Lookup on the current PC
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            pred_taken;
  logic [31:0]     pred_pc;
  logic [31:0]     npc;

  assign lk_idx     = pc[2 +: IDX];
  assign lk_tag     = pc[31 : 2+IDX];
  assign lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && btb_ctr[lk_idx][1];
  assign pred_pc    = pred_taken ? btb_target[lk_idx] : '0;
  assign npc        = pred_taken ? btb_target[lk_idx] : pc + 32'd4;

  // Update side
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic            unused_up_bits;

  assign up_idx         = btb_update_pc[2 +: IDX];
  assign up_tag         = btb_update_pc[31 : 2+IDX];
  assign up_hit         = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  assign unused_up_bits = ^btb_update_pc[1:0];

  // Non-blocking writes mean a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid  <= '0;
      btb_ctr    <= '{default: 2'b01};
      btb_tag    <= '{default: '0};
      btb_target <= '{default: '0};
    end else if (btb_update) begin
      if (up_hit) begin
        if (btb_update_taken) begin
          if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
          btb_target[up_idx] <= btb_update_target;
        end else if (btb_ctr[up_idx] != 2'b00) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
        end
      end else if (btb_update_taken) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= up_tag;
        btb_ctr[up_idx]    <= 2'b10;
        btb_target[up_idx] <= btb_update_target;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (redirect)                   state_nxt = imem_resp ? FETCH : DISCARD;
        else if (imem_resp && stall_in) state_nxt = HOLD;
      end
      HOLD: begin
        if (redirect || !stall_in) state_nxt = FETCH;
      end
      DISCARD: begin
        if (imem_resp) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_read       = 1'b0;
    pc_reg          = pc;
    instr_mem_rdata = NOP;
    br_pred_taken   = 1'b0;
    br_pred_pc      = '0;
    fetch_valid     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_read = 1'b1;
          if (imem_resp && !redirect) begin
            instr_mem_rdata = imem_rdata;
            br_pred_taken   = pred_taken;
            br_pred_pc      = pred_pc;
            fetch_valid     = 1'b1;
          end
        end
        HOLD: begin
          if (!redirect) begin
            instr_mem_rdata = hold_word;
            br_pred_taken   = hold_taken;
            br_pred_pc      = hold_pred_pc;
            fetch_valid     = 1'b1;
          end
        end
        DISCARD: imem_read = 1'b1;
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;

  // PC, pending redirect and hold buffer. The PC is left untouched while a
  // read is outstanding so imem_addr stays stable until imem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      saved_redirect_pc <= '0;
      hold_word         <= NOP;
      hold_taken        <= 1'b0;
      hold_pred_pc      <= '0;
      hold_npc          <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_resp) pc <= redirect_pc;
            else           saved_redirect_pc <= redirect_pc;
          end else if (imem_resp) begin
            if (stall_in) begin
              hold_word    <= imem_rdata;
              hold_taken   <= pred_taken;
              hold_pred_pc <= pred_pc;
              hold_npc     <= npc;
            end else begin
              pc <= npc;
            end
          end
        end
        HOLD: begin
          if (redirect)       pc <= redirect_pc;
          else if (!stall_in) pc <= hold_npc;
        end
        DISCARD: begin
          // A redirect arriving with the response is the newest one.
          if (imem_resp)     pc <= redirect ? redirect_pc : saved_redirect_pc;
          else if (redirect) saved_redirect_pc <= redirect_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Each step advances one clock, drives the inputs for that cycle 1 ns after
// the rising edge and checks the outputs 2 ns later.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h6000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] UPC    = 32'h6000_0010;
  localparam logic [31:0] UTGT   = 32'h6000_0040;
  localparam int          NONE   = 0;
  localparam int          TKN    = 1;
  localparam int          NTKN   = 2;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        btb_update;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;
  logic        btb_update_taken;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] pc_reg;
  logic [31:0] instr_mem_rdata;
  logic        br_pred_taken;
  logic [31:0] br_pred_pc;
  logic        fetch_valid;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .RESET_PC    (32'h6000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_in          (stall_in),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .btb_update        (btb_update),
    .btb_update_pc     (btb_update_pc),
    .btb_update_target (btb_update_target),
    .btb_update_taken  (btb_update_taken),
    .imem_read         (imem_read),
    .imem_addr         (imem_addr),
    .imem_resp         (imem_resp),
    .imem_rdata        (imem_rdata),
    .pc_reg            (pc_reg),
    .instr_mem_rdata   (instr_mem_rdata),
    .br_pred_taken     (br_pred_taken),
    .br_pred_pc        (br_pred_pc),
    .fetch_valid       (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; reset is released by every call.
  task automatic cyc(input logic resp, input logic [31:0] rdata, input logic stall,
                     input logic rdr, input logic [31:0] rpc, input int upd);
    @(posedge clk);
    #1;
    rst               = 1'b0;
    imem_resp         = resp;
    imem_rdata        = rdata;
    stall_in          = stall;
    redirect          = rdr;
    redirect_pc       = rpc;
    btb_update        = (upd != NONE);
    btb_update_pc     = UPC;
    btb_update_target = UTGT;
    btb_update_taken  = (upd == TKN);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    stall_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
    btb_update = 1'b0; btb_update_pc = '0; btb_update_target = '0; btb_update_taken = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;

    // Reset cycle
    @(posedge clk);
    #3;
    chk1 ("rst_read",  imem_read, 1'b0);
    chk1 ("rst_valid", fetch_valid, 1'b0);
    chk32("rst_instr", instr_mem_rdata, NOP);
    chk1 ("rst_pred",  br_pred_taken, 1'b0);
    chk32("rst_ppc",   br_pred_pc, 32'h0);
    chk32("rst_pc",    pc_reg, RST_PC);

    // Sequential fetch, 1-cycle latency
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("f0_read", imem_read, 1'b1);
    chk32("f0_addr", imem_addr, 32'h6000_0000);
    chk1 ("f0_wait_valid", fetch_valid, 1'b0);
    cyc(1'b1, NOP, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("f0_valid", fetch_valid, 1'b1);
    chk32("f0_pc",    pc_reg, 32'h6000_0000);
    chk32("f0_instr", instr_mem_rdata, NOP);
    chk1 ("f0_pred",  br_pred_taken, 1'b0);

    // Response at 0004 meets a 3-cycle stall
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("f1_addr", imem_addr, 32'h6000_0004);
    cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0, NONE);
    chk1 ("f1_valid", fetch_valid, 1'b1);
    chk32("f1_pc",    pc_reg, 32'h6000_0004);
    chk32("f1_instr", instr_mem_rdata, 32'h0050_0093);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NONE);
    chk1 ("hold1_read",  imem_read, 1'b0);
    chk1 ("hold1_valid", fetch_valid, 1'b1);
    chk32("hold1_pc",    pc_reg, 32'h6000_0004);
    chk32("hold1_instr", instr_mem_rdata, 32'h0050_0093);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NONE);
    chk1 ("hold2_read",  imem_read, 1'b0);
    chk32("hold2_instr", instr_mem_rdata, 32'h0050_0093);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("hold_rel_valid", fetch_valid, 1'b1);
    chk1 ("hold_rel_read",  imem_read, 1'b0);

    // Redirect while 0008 is outstanding; a second redirect overrides the first
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h6000_0080, NONE);
    chk1 ("f2_read",  imem_read, 1'b1);
    chk32("f2_addr",  imem_addr, 32'h6000_0008);
    chk1 ("f2_valid", fetch_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h6000_0100, NONE);
    chk1 ("disc_read", imem_read, 1'b1);
    chk32("disc_addr", imem_addr, 32'h6000_0008);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("disc_resp_valid", fetch_valid, 1'b0);
    chk32("disc_resp_addr",  imem_addr, 32'h6000_0008);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, TKN);
    chk32("redir_addr", imem_addr, 32'h6000_0100);
    chk1 ("redir_read", imem_read, 1'b1);

    // Second taken update, then redirect+stall with response drops the word
    cyc(1'b1, NOP, 1'b0, 1'b0, 32'h0, TKN);
    chk1 ("f100_valid", fetch_valid, 1'b1);
    chk1 ("f100_pred",  br_pred_taken, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("f104_addr", imem_addr, 32'h6000_0104);
    cyc(1'b1, NOP, 1'b1, 1'b1, 32'h6000_0010, NONE);
    chk1 ("rdst_valid", fetch_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("rdst_addr", imem_addr, 32'h6000_0010);

    // Fetch of 0010 with counter at 2'b11 predicts taken
    cyc(1'b1, 32'h0300_0063, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("btb_t_valid", fetch_valid, 1'b1);
    chk32("btb_t_pc",    pc_reg, 32'h6000_0010);
    chk1 ("btb_t_pred",  br_pred_taken, 1'b1);
    chk32("btb_t_ppc",   br_pred_pc, 32'h6000_0040);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NTKN);
    chk32("btb_t_next", imem_addr, 32'h6000_0040);

    // Three not-taken updates bring the counter to 2'b00
    cyc(1'b1, NOP, 1'b0, 1'b0, 32'h0, NTKN);
    chk1 ("f40_pred", br_pred_taken, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NTKN);
    chk32("f44_addr", imem_addr, 32'h6000_0044);
    cyc(1'b1, NOP, 1'b0, 1'b1, 32'h6000_0010, NONE);
    chk1 ("f44_drop", fetch_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("f10b_addr", imem_addr, 32'h6000_0010);
    cyc(1'b1, 32'h0300_0063, 1'b0, 1'b0, 32'h0, NONE);
    chk1 ("btb_nt_valid", fetch_valid, 1'b1);
    chk1 ("btb_nt_pred",  br_pred_taken, 1'b0);
    chk32("btb_nt_ppc",   br_pred_pc, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("btb_nt_next", imem_addr, 32'h6000_0014);

    // Redirect while holding drops the buffered word
    cyc(1'b1, 32'h0010_0113, 1'b1, 1'b0, 32'h0, NONE);
    chk1 ("f14_valid", fetch_valid, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0200, NONE);
    chk1 ("hold_rdr_valid", fetch_valid, 1'b0);
    chk1 ("hold_rdr_read",  imem_read, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("hold_rdr_addr", imem_addr, 32'h6000_0200);

    // Reset mid-transaction with a response in the reset cycle
    @(posedge clk);
    #1;
    rst = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h1234_5678;
    #2;
    chk1("mrst_read",  imem_read, 1'b0);
    chk1("mrst_valid", fetch_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NONE);
    chk32("mrst_addr",  imem_addr, RST_PC);
    chk1 ("mrst_read2", imem_read, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the rv32i pipeline; sits directly upstream of the IF/ID pipeline register and drives its pc_reg, instr_mem_rdata, br_pred_taken_in and br_pred_pc_in inputs.
- Owns the PC register, the instruction-memory read handshake and a small direct-mapped BTB with 2-bit counters.
- Honours back-pressure from the hazard unit and redirects from EX on mispredict.

Parameters:
- RESET_PC, 32'h6000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX = log2(BTB_ENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall_in  in  1  downstream (IF/ID) cannot accept; same signal that drives IF/ID stall
- redirect  in  1  EX-stage mispredict/jump; fetch must restart at redirect_pc
- redirect_pc  in  32  corrected PC
- btb_update  in  1  resolved control-flow instruction in EX
- btb_update_pc  in  32  PC of the resolved instruction
- btb_update_target  in  32  resolved target
- btb_update_taken  in  1  resolved direction
- imem_read  out  1  instruction-memory read request
- imem_addr  out  32  read address; word aligned
- imem_resp  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- pc_reg  out  32  PC of the instruction presented
- instr_mem_rdata  out  32  instruction presented
- br_pred_taken  out  1  BTB predicted taken for the presented instruction
- br_pred_pc  out  32  predicted next PC (0 when not taken)
- fetch_valid  out  1  presented instruction is real; when low the hazard unit flushes IF/ID (bubble)

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- Reset values:
  - pc = RESET_PC, FSM = FETCH.
  - imem_read = 0 during the reset cycle.
  - instr_mem_rdata = 32'h0000_0013 (nop), br_pred_taken = 0, br_pred_pc = 0, fetch_valid = 0.
  - All BTB valid bits cleared, counters = 2'b01.
- Memory protocol:
  - imem_addr = pc and must stay stable while imem_read = 1 until imem_resp.
  - Response latency is at least 1 cycle.
  - imem_resp is never asserted without an outstanding read.
- Next PC:
  - npc = btb_target if (BTB hit && counter[1]), else pc + 4 (32-bit wrap).
  - br_pred_taken / br_pred_pc reflect that choice for the presented instruction.
- BTB:
  - Index = pc[2 +: IDX]; tag = pc[31 : 2+IDX]. Lookup is combinational on the current pc.
  - Update on btb_update, indexed by btb_update_pc.
  - On a tag hit: counter saturating +1 if taken, -1 if not; target written when taken.
  - On a miss with taken: allocate with valid = 1, counter = 2'b10, target written.
  - On a miss with not-taken: no change.
  - Same-cycle update and lookup of the same entry: lookup returns the old contents.
- FSM states FETCH, HOLD, DISCARD:
  - FETCH: imem_read = 1.
    - On imem_resp with no redirect and no stall_in: present the word with fetch_valid = 1 this cycle; pc <= npc; stay in FETCH.
    - On imem_resp with stall_in = 1: present the word with fetch_valid = 1, latch word and prediction into a hold buffer; go to HOLD.
    - No imem_resp: fetch_valid = 0.
  - HOLD: imem_read = 0; present the buffered word with fetch_valid = 1.
    - When stall_in = 0: pc <= buffered npc; go to FETCH.
  - DISCARD: an outstanding read is being abandoned. imem_read = 1 at the old address; fetch_valid = 0.
    - On imem_resp: drop the data, pc <= saved redirect_pc; go to FETCH.
- Redirect (highest priority):
  - FETCH with imem_resp, or HOLD: drop the word, fetch_valid = 0, pc <= redirect_pc, go to FETCH.
  - FETCH without imem_resp: save redirect_pc; go to DISCARD.
  - DISCARD: overwrite the saved redirect_pc (the last redirect wins).
- Redirect has priority over stall_in.
- Reset mid-transaction: state and PC return to reset values; any in-flight response is ignored only in the reset cycle.
- fetch_valid is never 1 for a word fetched from a PC preceding a redirect.

Test Plan:
- Reset, then imem returns 32'h0000_0013 with 1-cycle latency for 4 fetches -> imem_addr sequence 6000_0000, 0004, 0008, 000C; fetch_valid pulses each response; br_pred_taken = 0.
- stall_in held high for 3 cycles when the response at 6000_0004 arrives -> imem_read = 0; pc_reg = 6000_0004 and word held for 3 cycles; next request at 6000_0008.
- redirect to 6000_0100 while a read at 6000_0008 is outstanding (response 2 cycles later) -> imem_addr stays 6000_0008 until imem_resp; that data gets fetch_valid = 0; next imem_addr = 6000_0100.
- Two btb_update events, taken, pc 6000_0010, target 6000_0040 -> counter reaches 2'b11; next fetch of 6000_0010 gives br_pred_taken = 1, br_pred_pc = 6000_0040; next imem_addr = 6000_0040.
- Three not-taken updates for the same entry -> counter reaches 2'b00; fetch of 6000_0010 falls through to 6000_0014 with br_pred_taken = 0.
- redirect and stall_in asserted in the same cycle as imem_resp -> word dropped (fetch_valid = 0); next imem_addr = redirect_pc.
